fft_frame_sched: RTL and testbench

- Frame scheduler in front of the radix-2^2 SDF FFT pipeline in the audio-processing path.
- Accepts real audio samples through a valid/ready handshake into a ping-pong buffer of two N-sample banks.
- Issues each full frame to the FFT as one contiguous N-cycle di_en burst.
- Tags FFT output samples with their natural-order bin index and signals frame completion.

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_frame_bank.sv | 26 ++
 rtl/fft_frame_sched.sv | 127 ++++++++++++
 tb/tb_fft_frame_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, read-FSM encoding and index helpers for the FFT frame scheduler.
package fft_pkg;
    localparam int FFT_N = 64;
    localparam int FFT_WIDTH = 16;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd1, ST_GAP = 2'd2} rd_state_e;
    function automatic int LOG2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
    // Reverses the low 'bits' bits of v; SDF output order is bit-reversed.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) if (i < bits) r[i] = v[bits-1-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: two N-entry sample banks with a synchronous write port and a registered read port.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int WIDTH = FFT_WIDTH,
    localparam int AW = LOG2(N) + 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [2*N];
    logic [WIDTH-1:0] r_rdata;
    always_ff @(posedge i_clock) if (i_we) r_mem[i_waddr] <= i_wdata;
    // Idle cycles read back zero so the FFT input stays quiet between bursts.
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) r_rdata <= '0;
        else r_rdata <= i_re ? r_mem[i_raddr] : '0;
    assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: ping-pong frame buffer issuing N-cycle FFT bursts and tagging FFT output bins.
module fft_frame_sched
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int WIDTH = FFT_WIDTH,
    parameter int MIN_GAP = 1,
    localparam int LB = LOG2(N),
    localparam int GW = LOG2(MIN_GAP + 1) + 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_fft_di_en,
    output logic [WIDTH-1:0] o_fft_di_re,
    output logic [WIDTH-1:0] o_fft_di_im,
    input  logic             i_fft_do_en,
    input  logic [WIDTH-1:0] i_fft_do_re,
    input  logic [WIDTH-1:0] i_fft_do_im,
    output logic             o_out_en,
    output logic [WIDTH-1:0] o_out_re,
    output logic [WIDTH-1:0] o_out_im,
    output logic [LB-1:0]    o_out_bin,
    output logic             o_frame_done,
    output logic             o_busy
);
    logic [1:0]       r_full, r_inflight, w_set, w_clr;
    logic             r_wr_bank, r_rd_bank, r_di_en, r_out_en, r_frame_done;
    logic [LB-1:0]    r_wr_cnt, r_rd_cnt, r_do_cnt, r_out_bin;
    logic [GW-1:0]    r_gap_cnt;
    logic [WIDTH-1:0] r_out_re, r_out_im;
    logic             w_wr, w_wr_last, w_rd, w_rd_last, w_start, w_do_last;
    rd_state_e        r_state, w_next;

    assign o_s_ready = ~r_full[r_wr_bank];
    assign w_wr      = i_s_valid & o_s_ready;
    assign w_wr_last = w_wr & (r_wr_cnt == LB'(N - 1));
    assign w_set     = {1'b0, w_wr_last} << r_wr_bank;
    assign w_do_last = i_fft_do_en & (r_do_cnt == LB'(N - 1));

    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) r_state <= ST_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE)
            w_next = r_full[r_rd_bank] ? ST_BURST : ST_IDLE;
        else if (r_state == ST_BURST && r_rd_cnt == LB'(N - 1))
            w_next = MIN_GAP > 0 ? ST_GAP : (r_full[~r_rd_bank] ? ST_BURST : ST_IDLE);
        else if (r_state == ST_GAP && r_gap_cnt == GW'(MIN_GAP - 1))
            w_next = r_full[r_rd_bank] ? ST_BURST : ST_IDLE;
    end

    // A new frame starts whenever BURST is entered, including a back-to-back re-entry.
    always_comb begin
        w_rd      = r_state == ST_BURST;
        w_rd_last = w_rd & (r_rd_cnt == LB'(N - 1));
        w_start   = (w_next == ST_BURST) & (~w_rd | w_rd_last);
        w_clr     = {1'b0, w_rd_last} << r_rd_bank;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_bank  <= 1'b0;
            r_rd_cnt   <= '0;
            r_gap_cnt  <= '0;
            r_di_en    <= 1'b0;
            r_inflight <= '0;
        end else begin
            r_full    <= (r_full | w_set) & ~w_clr;
            if (w_wr) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_wr_last) r_wr_bank <= ~r_wr_bank;
            if (w_rd) r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_rd_last) r_rd_bank <= ~r_rd_bank;
            r_gap_cnt <= r_state == ST_GAP ? r_gap_cnt + 1'b1 : '0;
            r_di_en   <= w_rd;
            if (w_start & ~w_do_last & r_inflight != 2'd3) r_inflight <= r_inflight + 1'b1;
            else if (w_do_last & ~w_start & r_inflight != 2'd0) r_inflight <= r_inflight - 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_do_cnt     <= '0;
            r_out_en     <= 1'b0;
            r_out_re     <= '0;
            r_out_im     <= '0;
            r_out_bin    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_en     <= i_fft_do_en;
            r_frame_done <= w_do_last;
            if (i_fft_do_en) begin
                r_do_cnt  <= r_do_cnt + 1'b1;
                r_out_re  <= i_fft_do_re;
                r_out_im  <= i_fft_do_im;
                r_out_bin <= LB'(bitrev(32'(r_do_cnt), LB));
            end
        end
    end

    fft_frame_bank #(.N(N), .WIDTH(WIDTH)) u_bank (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_we   (w_wr),
        .i_waddr({r_wr_bank, r_wr_cnt}),
        .i_wdata(i_s_data),
        .i_re   (w_rd),
        .i_raddr({r_rd_bank, r_rd_cnt}),
        .o_rdata(o_fft_di_re)
    );

    assign o_fft_di_en  = r_di_en;
    assign o_fft_di_im  = '0;
    assign o_out_en     = r_out_en;
    assign o_out_re     = r_out_re;
    assign o_out_im     = r_out_im;
    assign o_out_bin    = r_out_bin;
    assign o_frame_done = r_frame_done;
    assign o_busy       = |r_full | (r_state != ST_IDLE) | (r_inflight != 2'd0);
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: randomized streams checked against a frame-level timing and data model.
module tb_fft_frame_sched;
    localparam int N = 64, W = 16, MIN_GAP = 1, LB = 6;
    logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, do_en = 1'b0;
    logic [W-1:0] s_data = '0, do_re = '0, do_im = '0;
    logic s_ready, di_en, out_en, frame_done, busy;
    logic [W-1:0] di_re, di_im, out_re, out_im;
    logic [LB-1:0] out_bin;
    logic [74:0] rst_word;
    int vectors = 0, errors = 0, cyc = 0;
    int q_start[$], q_len[$], hs[$], r_cyc[$], r_j[$];
    logic [W-1:0] q_di[$], acc[$];
    bit r_rdy[$];
    int idle_nz = 0, im_nz = 0, m_run = 0;
    bit m_prev = 0;

    fft_frame_sched #(.N(N), .WIDTH(W), .MIN_GAP(MIN_GAP)) dut (
        .i_clock(clk), .i_reset(rst), .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
        .o_fft_di_en(di_en), .o_fft_di_re(di_re), .o_fft_di_im(di_im),
        .i_fft_do_en(do_en), .i_fft_do_re(do_re), .i_fft_do_im(do_im),
        .o_out_en(out_en), .o_out_re(out_re), .o_out_im(out_im), .o_out_bin(out_bin),
        .o_frame_done(frame_done), .o_busy(busy)
    );

    assign rst_word = {s_ready, di_en, di_re, di_im, out_en, out_re, out_im, out_bin, frame_done, busy};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Burst monitor: start cycle and length of every di_en run, plus the data it carried.
    always @(negedge clk) begin
        if (rst) begin
            m_prev = 0;
            m_run = 0;
        end else begin
            if (di_im !== '0) im_nz++;
            if (di_en) begin
                if (!m_prev) q_start.push_back(cyc);
                q_di.push_back(di_re);
                m_run++;
            end else begin
                if (m_prev) q_len.push_back(m_run);
                m_run = 0;
                if (di_re !== '0) idle_nz++;
            end
            m_prev = di_en;
        end
    end

    function automatic int rev(input int x);
        int r = 0;
        for (int b = 0; b < LB; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic drive(input int n, input int pv, input bit tg, input bit seq);
        int sent = 0, t = 0;
        while (sent < n && t < n * 4 + 400) begin
            @(posedge clk); #1;
            s_valid = tg ? (t % 2 == 0) : ($urandom_range(0, 99) < pv);
            s_data = seq ? W'(sent) : W'($urandom);
            @(negedge clk);
            r_cyc.push_back(cyc);
            r_j.push_back(sent);
            r_rdy.push_back(s_ready);
            if (s_valid && s_ready) begin
                hs.push_back(cyc);
                acc.push_back(s_data);
                sent++;
            end
            t++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (rst_word !== {1'b1, 74'd0}) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", rst_word, {1'b1, 74'd0});
        end
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Expected burst start: the frame's last sample plus the 3-cycle fill latency, but never
    // sooner than MIN_GAP idle cycles after the previous burst's last di_en cycle.
    task automatic test_stream(input string name, input int nf, input int pv, input bit tg, input bit seq);
        int es[$], ee[$];
        int t = 0, nfo, s, k, e;
        q_start = {}; q_len = {}; q_di = {}; acc = {}; hs = {}; r_cyc = {}; r_j = {}; r_rdy = {};
        idle_nz = 0; im_nz = 0;
        drive(nf * N, pv, tg, seq);
        while (q_len.size() < nf && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        nfo = hs.size() / N;
        for (int f = 0; f < nfo; f++) begin
            s = hs[f * N + N - 1] + 3;
            if (f > 0 && ee[f-1] + MIN_GAP + 1 > s) s = ee[f-1] + MIN_GAP + 1;
            es.push_back(s);
            ee.push_back(s + N - 1);
        end
        vectors++;
        if (q_len.size() !== nf) begin
            errors++;
            $display("FAIL %s burst_count: got %0d want %0d", name, q_len.size(), nf);
        end
        for (int f = 0; f < nf && f < q_len.size() && f < nfo; f++) begin
            vectors += 2;
            if (q_start[f] !== es[f]) begin
                errors++;
                $display("FAIL %s burst_start[%0d]: got %0d want %0d", name, f, q_start[f], es[f]);
            end
            if (q_len[f] !== N) begin
                errors++;
                $display("FAIL %s burst_len[%0d]: got %0d want %0d", name, f, q_len[f], N);
            end
        end
        vectors++;
        if (q_di.size() !== acc.size()) begin
            errors++;
            $display("FAIL %s sample_count: got %0d want %0d", name, q_di.size(), acc.size());
        end
        for (int i = 0; i < q_di.size() && i < acc.size(); i++) begin
            vectors++;
            if (q_di[i] !== acc[i]) begin
                errors++;
                $display("FAIL %s di_re[%0d]: got %h want %h", name, i, q_di[i], acc[i]);
            end
        end
        for (int i = 0; i < r_cyc.size(); i++) begin
            k = r_j[i] / N;
            e = (r_j[i] % N != 0 || k < 2) ? 1 : (k - 2 < ee.size() && r_cyc[i] >= ee[k-2]);
            vectors++;
            if (r_rdy[i] !== e[0]) begin
                errors++;
                $display("FAIL %s s_ready@%0d: got %0d want %0d", name, r_cyc[i], r_rdy[i], e);
            end
        end
        vectors += 2;
        if (idle_nz !== 0) begin
            errors++;
            $display("FAIL %s idle_di_re_nonzero: got %0d want 0", name, idle_nz);
        end
        if (im_nz !== 0) begin
            errors++;
            $display("FAIL %s di_im_nonzero: got %0d want 0", name, im_nz);
        end
    endtask

    task automatic test_output_tagging();
        int k = 0, t = 0, p_bin = 0;
        bit p_en = 0, p_done = 0;
        logic [W-1:0] p_re = '0, p_im = '0, h_re = '0, h_im = '0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_inflight: got %b want 1", busy);
        end
        while ((k < N || p_en) && t < 1000) begin
            @(posedge clk); #1;
            do_en = (k < N) && ($urandom_range(0, 3) != 0);
            do_re = W'($urandom);
            do_im = W'($urandom);
            @(negedge clk);
            vectors += 4;
            if (out_en !== p_en) begin
                errors++;
                $display("FAIL out_en: got %b want %b", out_en, p_en);
            end
            if (frame_done !== (p_en && p_done)) begin
                errors++;
                $display("FAIL frame_done: got %b want %b", frame_done, p_en && p_done);
            end
            if (out_re !== (p_en ? p_re : h_re) || out_im !== (p_en ? p_im : h_im)) begin
                errors++;
                $display("FAIL out_data: got %h/%h want %h/%h", out_re, out_im, p_en ? p_re : h_re, p_en ? p_im : h_im);
            end
            if (p_en && out_bin !== LB'(p_bin)) begin
                errors++;
                $display("FAIL out_bin: got %0d want %0d", out_bin, p_bin);
            end
            if (p_en) begin
                h_re = p_re;
                h_im = p_im;
            end
            p_en = do_en;
            p_re = do_re;
            p_im = do_im;
            if (do_en) begin
                p_bin = rev(k);
                p_done = (k == N - 1);
                k++;
            end
            t++;
        end
        @(posedge clk); #1;
        do_en = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_frame: got %b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        q_di = {}; acc = {}; hs = {}; r_cyc = {}; r_j = {}; r_rdy = {};
        drive(N + 40, 100, 0, 0);
        vectors++;
        if (di_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_before_reset: got %b want 1", di_en);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (rst_word !== {1'b1, 74'd0}) begin
            errors++;
            $display("FAIL mid_reset_values: got %h want %h", rst_word, {1'b1, 74'd0});
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        test_stream("post_reset", 1, 100, 0, 0);
    endtask

    initial begin
        test_reset();
        test_stream("single_frame", 1, 100, 0, 1);
        test_output_tagging();
        test_stream("three_frames", 3, 100, 0, 0);
        test_stream("toggle_valid", 1, 0, 1, 0);
        test_mid_reset();
        test_stream("backpressure", 4, 100, 0, 0);
        test_stream("random_valid", 3, 70, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
